// File: rtl/wbdbgbus_arbiter.sv
// Two-master / one-slave pipelined Wishbone arbiter; master 0 (debug bus) has fixed priority.
// Optional hung-slave watchdog enabled by defining WBARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no grant, slave side held at 0
//   G0    | master 0 owns the bus until it drops cyc (or is aborted)
//   G1    | master 1 owns the bus until it drops cyc (or is aborted)
module wbdbgbus_arbiter #(
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic [31:0] o_m_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   req0, req1;
    logic   abort0, abort1;
    logic   wb_cyc_sel;

    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end

    assign wb_cyc_sel = ((state == G0) && i_m0_cyc) || ((state == G1) && i_m1_cyc);

`ifdef WBARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             lock0, lock1;
    logic             timeout;

    assign timeout = wb_cyc_sel && (to_cnt == CNT_W'(TIMEOUT_CLKS));
    assign abort0  = timeout && (state == G0);
    assign abort1  = timeout && (state == G1);
    assign req0    = i_m0_cyc && !lock0;
    assign req1    = i_m1_cyc && !lock1;

    // An aborted master stays locked out until it releases cyc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
            lock0  <= 1'b0;
            lock1  <= 1'b0;
        end else begin
            if (!wb_cyc_sel || i_wb_ack || i_wb_err || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            lock0 <= (lock0 || abort0) && i_m0_cyc;
            lock1 <= (lock1 || abort1) && i_m1_cyc;
        end
    end
`else
    assign abort0 = 1'b0;
    assign abort1 = 1'b0;
    assign req0   = i_m0_cyc;
    assign req1   = i_m1_cyc;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0)
                    state_next = G0;
                else if (req1)
                    state_next = G1;
            end
            G0: begin
                if (!i_m0_cyc || abort0)
                    state_next = req1 ? G1 : IDLE;
            end
            G1: begin
                if (!i_m1_cyc || abort1)
                    state_next = req0 ? G0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_stall = 1'b1;
        case (state)
            G0: begin
                o_wb_cyc   = i_m0_cyc && !abort0;
                o_wb_stb   = i_m0_stb && !abort0;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_m0_ack   = i_m0_cyc && i_wb_ack && !abort0;
                o_m0_err   = i_m0_cyc && (i_wb_err || abort0);
                o_m0_stall = i_wb_stall || abort0;
            end
            G1: begin
                o_wb_cyc   = i_m1_cyc && !abort1;
                o_wb_stb   = i_m1_stb && !abort1;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_m1_ack   = i_m1_cyc && i_wb_ack && !abort1;
                o_m1_err   = i_m1_cyc && (i_wb_err || abort1);
                o_m1_stall = i_wb_stall || abort1;
            end
            default: ;
        endcase
    end

    assign o_m_data = i_wb_data;
    assign o_grant  = {state == G1, state == G0};

endmodule
